ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
PS/2 device-to-host frame receiver. It is the stage directly upstream of the keyboard scan-code interpreter. It synchronises and deglitches the raw PS/2 clock and data lines, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good byte is delivered as a one-cycle strobe, which the interpreter consumes on its byte/convert inputs.

Parameters:
CLK_FREQ_HZ, 25000000, system clock frequency; documentation only, used to derive the defaults below.
FILTER_LEN, 8, consecutive equal synchronised samples required before the filtered PS/2 clock changes level (range 2..16).
TIMEOUT_CYCLES, 25000, maximum i_clk cycles allowed between falling edges inside a frame (1 ms at 25 MHz).

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_ps2_clk  input  1  raw PS/2 clock from the pad, asynchronous
i_ps2_data  input  1  raw PS/2 data from the pad, asynchronous
o_data  output  8  last correctly received byte; held until the next good frame
o_data_valid  output  1  one-cycle strobe; o_data is new this cycle
o_parity_err  output  1  one-cycle strobe; frame dropped on odd-parity failure
o_frame_err  output  1  one-cycle strobe; frame dropped on bad stop bit or timeout

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - o_data=8'h00; o_data_valid, o_parity_err, o_frame_err = 0.
  - State IDLE; bit counter 0; timeout counter 0.
  - Both 2-FF synchronisers, the filter history and the filtered clock reset to 1 (bus idle high). No spurious edge may follow reset release.
- Synchronisation: i_ps2_clk and i_ps2_data each pass through a 2-FF synchroniser.
- Filter: the filtered clock takes a new level only after FILTER_LEN consecutive synchronised clock samples at that level. Shorter pulses are ignored.
- Falling edge: fall = filtered clock was 1 last cycle and is 0 this cycle. Data is sampled from the synchronised data line in the fall cycle.
- State machine (all transitions on fall unless stated):
  - IDLE: data=0 -> DATA, bit counter=0. data=1 -> stay in IDLE; treated as noise, no error.
  - DATA: shift the sample into bit [counter], LSB first, and increment the counter. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP:
    - data=1 and (XOR of 8 data bits ^ parity)=1: o_data<=byte, o_data_valid=1 for exactly one cycle.
    - data=1 and parity check fails: o_parity_err=1 for one cycle; o_data unchanged.
    - data=0: o_frame_err=1 for one cycle; o_data unchanged. The stop check takes priority over the parity check.
    - All three cases -> IDLE.
- Latency: the strobe is registered and asserts on the cycle after the stop-bit fall.
- Strobes are mutually exclusive. At most one strobe asserts per frame.
- Timeout: in DATA, PARITY or STOP, the counter increments every cycle and clears on each fall.
  - Reaching TIMEOUT_CYCLES-1 -> o_frame_err one cycle, -> IDLE, partial byte discarded.
  - If a fall coincides with the timeout, the fall wins.
  - The counter is held at 0 in IDLE.
- Back-to-back frames: IDLE is re-entered on the stop fall, so the next start bit is accepted at the next fall with no dead time.
- Mid-frame reset: abort immediately. Afterwards, the first start bit begins a clean frame.
- Host-to-device transmission (clock inhibit) is out of scope. A line held low is ignored unless it produces a fall.

Test Plan:
- Single byte: PS/2 clock period 2000 cycles, frame 0x1D with parity 1 -> o_data_valid high exactly 1 cycle, o_data=8'h1D, no error strobes.
- Make/break sequence: frames 0xE0 (parity 0), 0xF0 (parity 1), 0x75 (parity 0) with 2 idle bit-times between them -> three valid strobes in order, o_data 8'hE0, 8'hF0, 8'h75; o_data holds 8'h75 afterwards.
- Parity error: 0x5A sent with parity 0 -> o_parity_err 1 cycle, no valid strobe, o_data keeps its previous value. Stop bit 0 on a good 0x29 -> o_frame_err only.
- Glitch rejection: 4-cycle low pulses on i_ps2_clk at idle and mid-bit during a 0x1C frame -> frame still received as 8'h1C, no error strobes.
- Timeout: stop the clock after 5 data bits -> o_frame_err exactly TIMEOUT_CYCLES after the last fall. A following full 0x23 frame is received correctly.
- Reset: assert i_rst_n=0 after 4 bits of a frame -> all outputs 0 asynchronously. After release, frame 0x1B -> o_data=8'h1B with a single valid strobe.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the pad lines,
// then deserialises start/8 data/odd parity/stop frames into one-cycle strobes.
module ps2_rx #(
    parameter int CLK_FREQ_HZ    = 25000000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam int FLEN = (FILTER_LEN < 2) ? 2 : ((FILTER_LEN > 16) ? 16 : FILTER_LEN);
    // A nonsensical timeout falls back to 1 ms of the system clock.
    localparam int TOUT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : (CLK_FREQ_HZ / 1000);
    localparam int TW   = (TOUT > 2) ? $clog2(TOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic [FLEN-1:0] r_hist;
    logic            r_filt;
    logic            r_filt_d;

    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_parity;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_perr;
    logic            r_ferr;

    logic            w_data;
    logic            w_fall;
    logic            w_timeout;
    logic            w_valid_next;
    logic            w_perr_next;
    logic            w_ferr_next;

    // Everything idles high so reset release never manufactures a falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_hist     <= '1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_hist     <= {r_hist[FLEN-2:0], r_clk_sync[1]};
            r_filt_d   <= r_filt;
            if (~|r_hist) begin
                r_filt <= 1'b0;
            end else if (&r_hist) begin
                r_filt <= 1'b1;
            end
        end
    end

    assign w_data    = r_dat_sync[1];
    assign w_fall    = r_filt_d & ~r_filt;
    assign w_timeout = (r_tcnt == TW'(TOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_perr_next  = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_data) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end
                end else if (w_timeout) begin
                    w_ferr_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_state_next = S_STOP;
                end else if (w_timeout) begin
                    w_ferr_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_next = S_IDLE;
                    // A bad stop bit outranks the parity verdict.
                    if (!w_data) begin
                        w_ferr_next = 1'b1;
                    end else if (^{r_shift, r_parity}) begin
                        w_valid_next = 1'b1;
                    end else begin
                        w_perr_next = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_ferr_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_parity <= 1'b0;
            r_tcnt   <= '0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
            if (w_valid_next) begin
                r_data <= r_shift;
            end

            if (w_fall || w_state_next == S_IDLE) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_bitcnt <= 3'd0;
                        r_shift  <= 8'h00;
                    end
                    S_DATA: begin
                        r_shift[r_bitcnt] <= w_data;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: begin
                        r_parity <= w_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed frames push expected strobes (kind, byte,
// cycle); a negedge monitor pops and compares each strobe the receiver emits.
module tb_ps2_rx;

    localparam int FILT = 8;
    localparam int TOUT = 3000;
    // Pad drive to visible strobe: 2 sync + FILT history + filtered reg + fall/strobe regs.
    localparam int LAT  = FILT + 4;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;
    localparam int K_NONE  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    ps2_rx #(
        .CLK_FREQ_HZ   (25000000),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard exactly.
    int   mon_n;
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_n = int'(o_data_valid) + int'(o_parity_err) + int'(o_frame_err);
            if (mon_n > 0) begin
                checks++;
                mon_kind = o_data_valid ? K_VALID : (o_parity_err ? K_PERR : K_FERR);
                if (mon_n > 1) begin
                    errors++;
                    $display("FAIL strobe_exclusive: cyc=%0d valid=%b perr=%b ferr=%b, required at most one",
                             cyc, o_data_valid, o_parity_err, o_frame_err);
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: cyc=%0d kind=%0d data=%02h, required no strobe",
                             cyc, mon_kind, o_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_kind != mon_e.kind || o_data != mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL strobe_match: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d",
                                 mon_kind, o_data, cyc, mon_e.kind, mon_e.data, mon_e.cyc);
                    end else begin
                        $display("strobe kind=%0d data=%02h cyc=%0d ok", mon_kind, o_data, cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nfalls bits of {stop, parity, byte, start}; on the stop fall
    // the caller's expected outcome is queued with its required cycle.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nfalls, input int half, input bit glitch,
                              input int exp_kind, input logic [7:0] exp_data,
                              output int last_fall);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        last_fall = 0;
        for (int i = 0; i < nfalls; i++) begin
            ps2_data = bits[i];
            wait_cycles(half / 2);
            if (glitch && (i == 0 || i == 4)) begin
                ps2_clk = 1'b0;
                wait_cycles(4);
                ps2_clk = 1'b1;
            end
            wait_cycles(half / 2);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == 10 && exp_kind != K_NONE) begin
                sb_q.push_back('{kind: exp_kind, data: exp_data, cyc: cyc + LAT});
            end
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        $display("frame byte=%02h par=%b stop=%b bits=%0d sent", b, par, stp, nfalls);
    endtask

    task automatic check_outputs(input string name, input logic [7:0] exp_data);
        checks++;
        if (o_data != exp_data || o_data_valid || o_parity_err || o_frame_err) begin
            errors++;
            $display("FAIL %s: data=%02h valid=%b perr=%b ferr=%b, required data=%02h no strobes",
                     name, o_data, o_data_valid, o_parity_err, o_frame_err, exp_data);
        end else begin
            $display("check %s data=%02h ok", name, o_data);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lf;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        check_outputs("reset_state", 8'h00);
        rst_n = 1'b1;
        wait_cycles(50);

        send_frame(8'h1D, 1'b1, 1'b1, 11, 1000, 1'b0, K_VALID, 8'h1D, lf);
        wait_cycles(2000);

        send_frame(8'hE0, 1'b0, 1'b1, 11, 200, 1'b0, K_VALID, 8'hE0, lf);
        wait_cycles(800);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 200, 1'b0, K_VALID, 8'hF0, lf);
        wait_cycles(800);
        send_frame(8'h75, 1'b0, 1'b1, 11, 200, 1'b0, K_VALID, 8'h75, lf);
        wait_cycles(400);
        check_outputs("hold_75", 8'h75);

        send_frame(8'h5A, 1'b0, 1'b1, 11, 200, 1'b0, K_PERR, 8'h75, lf);
        wait_cycles(800);
        send_frame(8'h29, 1'b0, 1'b0, 11, 200, 1'b0, K_FERR, 8'h75, lf);
        wait_cycles(800);

        send_frame(8'h1C, 1'b0, 1'b1, 11, 200, 1'b1, K_VALID, 8'h1C, lf);
        wait_cycles(800);

        // Start + 5 data bits, then the clock stops.
        send_frame(8'h34, 1'b0, 1'b1, 6, 200, 1'b0, K_NONE, 8'h00, lf);
        sb_q.push_back('{kind: K_FERR, data: 8'h1C, cyc: lf + LAT + TOUT});
        wait_cycles(TOUT + 200);
        send_frame(8'h23, 1'b0, 1'b1, 11, 200, 1'b0, K_VALID, 8'h23, lf);
        wait_cycles(800);

        // Reset mid-cycle, after start + 4 data bits.
        send_frame(8'h55, 1'b0, 1'b1, 5, 200, 1'b0, K_NONE, 8'h00, lf);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_reset", 8'h00);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(400);
        send_frame(8'h1B, 1'b1, 1'b1, 11, 200, 1'b0, K_VALID, 8'h1B, lf);
        wait_cycles(800);
        check_outputs("hold_1B", 8'h1B);

        wait_cycles(100);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
